// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - registered ALU micro-op sequencer with LW/SW expansion and MUL/DIV hold
module alu_op_sequencer #(
  parameter int OP_W    = 6,
  parameter int OPER_W  = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op_code,
  output logic [OPER_W-1:0] alu_oper,
  output logic              alu_oper_valid,
  output logic [1:0]        alu_step,
  output logic              op_done,
  output logic              op_illegal,
  output logic              busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_END = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_END = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state, state_nx;
  logic [OP_W-1:0] op_q, op_nx;
  logic [1:0]      step_q, step_nx;
  logic [CW-1:0]   cnt_q, cnt_nx;

  logic [3:0] oper4;
  logic [1:0] last_step;
  logic       illegal, is_mul, is_div;
  logic       hold, last, accept;

  // Decode works only on the latched opcode, so op_code never reaches alu_oper combinationally.
  always_comb begin
    oper4     = 4'd15;
    last_step = 2'd0;
    illegal   = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    case (op_q)
      OP_W'(0): begin
        last_step = 2'd2;
        case (step_q)
          2'd0:    oper4 = 4'd1;
          2'd1:    oper4 = 4'd5;
          default: oper4 = 4'd6;
        endcase
      end
      OP_W'(3): begin
        last_step = 2'd1;
        oper4     = (step_q == 2'd0) ? 4'd1 : 4'd5;
      end
      OP_W'(5):  oper4 = 4'd5;
      OP_W'(6):  oper4 = 4'd1;
      OP_W'(7):  oper4 = 4'd2;
      OP_W'(8):  begin oper4 = 4'd3; is_mul = 1'b1; end
      OP_W'(9):  begin oper4 = 4'd4; is_div = 1'b1; end
      OP_W'(10): oper4 = 4'd7;
      OP_W'(11): oper4 = 4'd8;
      OP_W'(12): oper4 = 4'd9;
      OP_W'(13): oper4 = 4'd10;
      OP_W'(14): oper4 = 4'd11;
      OP_W'(15): oper4 = 4'd12;
      OP_W'(16), OP_W'(17), OP_W'(19), OP_W'(20): oper4 = 4'd13;
      OP_W'(18): oper4 = 4'd14;
      OP_W'(21): oper4 = 4'd15;
      default:   illegal = 1'b1;
    endcase
  end

  assign hold   = (is_mul && cnt_q != MUL_END) || (is_div && cnt_q != DIV_END);
  assign last   = (state == EXEC) && !hold && (step_q == last_step);
  assign op_ready = !flush && ((state == IDLE) || last);
  assign accept = op_valid && op_ready;

  assign op_done        = last && !flush;
  assign op_illegal     = op_done && illegal;
  assign busy           = (state == EXEC);
  assign alu_oper_valid = (state == EXEC) && !illegal;
  assign alu_oper       = (state == EXEC) ? OPER_W'(oper4) : OPER_W'(4'd15);
  assign alu_step       = step_q;

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    step_nx  = step_q;
    cnt_nx   = cnt_q;
    if (flush) begin
      state_nx = IDLE;
      step_nx  = 2'd0;
      cnt_nx   = '0;
    end else if (accept) begin
      state_nx = EXEC;
      op_nx    = op_code;
      step_nx  = 2'd0;
      cnt_nx   = '0;
    end else if (state == EXEC) begin
      if (hold) begin
        cnt_nx = cnt_q + 1'b1;
      end else if (step_q < last_step) begin
        step_nx = step_q + 2'd1;
        cnt_nx  = '0;
      end else begin
        state_nx = IDLE;
        step_nx  = 2'd0;
        cnt_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      step_q <= 2'd0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      op_q   <= op_nx;
      step_q <= step_nx;
      cnt_q  <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized bench for alu_op_sequencer against a micro-op queue model
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       op_valid;
  logic [5:0] op_code;

  logic       rdy0, vld0, done0, ill0, busy0;
  logic [3:0] oper0;
  logic [1:0] step0;
  logic       rdy1, vld1, done1, ill1, busy1;
  logic [3:0] oper1;
  logic [1:0] step1;

  int n_tests = 0;
  int n_fail  = 0;

  // Each entry is one expected EXEC cycle: {illegal, done, step[1:0], valid, oper[3:0]}
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  localparam logic [9:0] IDLE_VEC = {1'b0, 9'b0_0_00_0_1111};

  always #5 clk = ~clk;

  alu_op_sequencer #(.OP_W(6), .OPER_W(4), .MUL_LAT(3), .DIV_LAT(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .op_valid(op_valid), .op_ready(rdy0),
    .op_code(op_code), .alu_oper(oper0), .alu_oper_valid(vld0), .alu_step(step0),
    .op_done(done0), .op_illegal(ill0), .busy(busy0)
  );

  alu_op_sequencer #(.OP_W(6), .OPER_W(4), .MUL_LAT(1), .DIV_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .op_valid(op_valid), .op_ready(rdy1),
    .op_code(op_code), .alu_oper(oper1), .alu_oper_valid(vld1), .alu_step(step1),
    .op_done(done1), .op_illegal(ill1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic int code_of(input int op);
    case (op)
      5: return 5;   6: return 1;   7: return 2;   10: return 7;
      11: return 8;  12: return 9;  13: return 10; 14: return 11;
      15: return 12; 16, 17, 19, 20: return 13;
      18: return 14; 21: return 15;
      default: return -1;
    endcase
  endfunction

  task automatic push_op(input int which, input int op);
    int ops[$];
    int c;
    logic ill;
    logic rep;
    logic [8:0] e;
    ill = 1'b0;
    rep = 1'b0;
    case (op)
      0: ops = '{1, 5, 6};
      3: ops = '{1, 5};
      8: begin rep = 1'b1; repeat (which ? 1 : 3) ops.push_back(3); end
      9: begin rep = 1'b1; repeat (which ? 2 : 8) ops.push_back(4); end
      default: begin
        c = code_of(op);
        if (c < 0) begin ill = 1'b1; ops = '{15}; end
        else ops = '{c};
      end
    endcase
    for (int i = 0; i < ops.size(); i++) begin
      e = {ill, (i == ops.size() - 1), (rep ? 2'd0 : 2'(i)), !ill, 4'(ops[i])};
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  function automatic logic [9:0] expect_vec(input logic [8:0] head, input logic has, input logic fl);
    logic [8:0] e;
    if (!has) return IDLE_VEC;
    e = head;
    if (fl) e[8:7] = 2'b00;
    return {1'b1, e};
  endfunction

  // One clock: inputs applied just after posedge, outputs checked at negedge, model advanced at posedge.
  task automatic cycle(input logic v, input logic [5:0] code, input logic fl);
    logic r0, r1;
    op_valid = v;
    op_code  = code;
    flush    = fl;
    @(negedge clk);
    r0 = !fl && (q0.size() <= 1);
    r1 = !fl && (q1.size() <= 1);
    check("d0 out", {busy0, ill0, done0, step0, vld0, oper0},
          expect_vec(q0.size() ? q0[0] : 9'd0, q0.size() != 0, fl));
    check("d0 rdy", rdy0, r0);
    check("d1 out", {busy1, ill1, done1, step1, vld1, oper1},
          expect_vec(q1.size() ? q1[0] : 9'd0, q1.size() != 0, fl));
    check("d1 rdy", rdy1, r1);
    @(posedge clk);
    if (fl) q0.delete();
    else begin
      if (q0.size() != 0) void'(q0.pop_front());
      if (v && r0) push_op(0, int'(code));
    end
    if (fl) q1.delete();
    else begin
      if (q1.size() != 0) void'(q1.pop_front());
      if (v && r1) push_op(1, int'(code));
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 6'd0, 1'b0);
  endtask

  task automatic do_reset;
    op_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst d0", {busy0, ill0, done0, step0, vld0, oper0}, IDLE_VEC);
    check("rst d1", {busy1, ill1, done1, step1, vld1, oper1}, IDLE_VEC);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    flush    = 1'b0;
    op_valid = 1'b0;
    op_code  = 6'd0;
    #2;
    do_reset();

    cycle(1'b1, 6'd6, 1'b0);
    idle(2);

    cycle(1'b1, 6'd0, 1'b0);
    idle(4);
    cycle(1'b1, 6'd3, 1'b0);
    idle(3);

    cycle(1'b1, 6'd8, 1'b0);
    idle(4);
    cycle(1'b1, 6'd9, 1'b0);
    idle(9);

    cycle(1'b1, 6'd10, 1'b0);
    cycle(1'b1, 6'd11, 1'b0);
    cycle(1'b1, 6'd14, 1'b0);
    cycle(1'b1, 6'd18, 1'b0);
    idle(2);

    foreach (q0[i]) ;
    cycle(1'b1, 6'd1, 1'b0);
    cycle(1'b1, 6'd2, 1'b0);
    cycle(1'b1, 6'd4, 1'b0);
    cycle(1'b1, 6'd22, 1'b0);
    cycle(1'b1, 6'd63, 1'b0);
    idle(2);

    cycle(1'b1, 6'd0, 1'b0);
    cycle(1'b0, 6'd0, 1'b0);
    cycle(1'b1, 6'd6, 1'b1);
    idle(2);

    cycle(1'b1, 6'd9, 1'b0);
    idle(3);
    do_reset();
    idle(2);

    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 27);
      cycle($urandom_range(0, 3) != 0, (r < 26) ? 6'(r) : 6'd63, $urandom_range(0, 19) == 0);
      if (i % 200 == 199) do_reset();
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Registered, parametrised successor to the combinational ALU operation decoder.
- Accepts instruction-level opcodes over a valid/ready handshake.
- Expands multi-step instructions into ALU micro-operation sequences: LW into 3 steps, SW into 2.
- Holds MUL/DIV operations stable for a configurable number of cycles.
- Sits between the main control FSM and the ALU, so the control FSM no longer steps LW/SW states itself.

Parameters:
OP_W, 6, instruction opcode width (≥6; upper bits beyond the table make the code illegal)
OPER_W, 4, ALU operation code width (≥4; codes zero-extended)
MUL_LAT, 3, cycles alu_oper holds ALU_MUL (≥1)
DIV_LAT, 8, cycles alu_oper holds ALU_DIV (≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of the current sequence
op_valid  in  1  opcode offered
op_ready  out  1  opcode accepted on a cycle where op_valid && op_ready
op_code  in  OP_W  instruction opcode
alu_oper  out  OPER_W  ALU operation for the current micro-step
alu_oper_valid  out  1  alu_oper is a live micro-op this cycle
alu_step  out  2  micro-step index within the instruction (0..2)
op_done  out  1  pulse on the last cycle of an instruction
op_illegal  out  1  pulse with op_done for an illegal opcode
busy  out  1  state != IDLE

Behaviour:
- Opcode table (decimal) -> micro-op sequence. Operation codes are ADD=1, SUB=2, MUL=3, DIV=4, MOV=5, SLW=6, AND=7, OR=8, SHL=9, SHR=10, CMP=11, NOT=12, JMP=13, BFJ=14, NOP=15.
  - 0 LW -> ADD, MOV, SLW
  - 3 SW -> ADD, MOV
  - 5 -> MOV
  - 6 -> ADD
  - 7 -> SUB
  - 8 -> MUL
  - 9 -> DIV
  - 10 -> AND
  - 11 -> OR
  - 12 -> SHL
  - 13 -> SHR
  - 14 -> CMP
  - 15 -> NOT
  - 16, 17, 19, 20 -> JMP
  - 18 -> BFJ
  - 21 -> NOP
  - All other codes (1, 2, 4, 22 and above) are illegal.
- States: IDLE, EXEC.
- Reset (async, rst_n=0): state=IDLE, alu_oper=15 (NOP), alu_oper_valid=0, alu_step=0, op_done=0, op_illegal=0, busy=0, hold counter=0, latched opcode cleared.
- IDLE:
  - alu_oper=NOP, alu_oper_valid=0.
  - Accept on op_valid && op_ready: latch op_code, step=0, counter=0, go to EXEC.
- EXEC:
  - alu_oper = table[latched op][step]. alu_oper_valid=1, except for illegal opcodes (0, with alu_oper=NOP).
  - MUL/DIV: stay while counter < LAT-1, counter increments each cycle.
  - Otherwise, if step < last step: step+1, counter=0.
  - Otherwise this is the last cycle: op_done=1 (and op_illegal=1 if the opcode is illegal).
- Latency:
  - Opcode accepted at edge N -> first micro-op visible in cycle N+1.
  - Single-cycle op: 1 EXEC cycle.
  - LW: 3 cycles. SW: 2 cycles. MUL: MUL_LAT cycles. DIV: DIV_LAT cycles.
- op_ready = !flush && (state==IDLE || last EXEC cycle).
  - Acceptance during the last EXEC cycle re-enters EXEC at step 0 with no bubble.
  - Single-cycle ops stream at 1 per cycle; without a new acceptance the block returns to IDLE.
- flush=1: next state IDLE, counter/step cleared. No op_done or op_illegal in that cycle. No acceptance in that cycle. Has priority over everything except rst_n.
- Illegal opcode: one EXEC cycle with alu_oper_valid=0, alu_oper=NOP, op_done=1, op_illegal=1.
- All outputs are decoded from registered state only. No combinational path from op_code to alu_oper.
- Reset asserted mid-sequence: immediate IDLE and reset values, no op_done.

Test Plan:
- Reset, then single ADD (6) -> one cycle of alu_oper=1, valid=1, step=0, op_done=1. Next cycle IDLE, alu_oper=15, busy=0.
- LW (0) -> alu_oper 1, 5, 6 on 3 consecutive cycles, alu_step 0, 1, 2, op_done only in the third cycle. SW (3) -> 1, 5, op_done in the second cycle.
- MUL (8) with MUL_LAT=3 -> alu_oper=3 for exactly 3 cycles, op_done in cycle 3. DIV with DIV_LAT=8 -> 8 cycles of 4. Rerun with MUL_LAT=1 -> 1 cycle.
- Back-to-back stream AND, OR, CMP, BRFL(18), op_valid held high -> alu_oper 7, 8, 11, 14 on consecutive cycles, op_ready=1 throughout, 4 op_done pulses.
- Illegal codes 1, 2, 4, 22 -> each gives one cycle of alu_oper=15, alu_oper_valid=0, op_done=1, op_illegal=1.
- Boundary/abort cases:
  - flush on LW step 1 -> next cycle IDLE, no op_done, op_ready=0 during the flush cycle.
  - rst_n low mid-DIV -> outputs immediately at reset values.
